mac_array_ctrl: RTL and testbench
=================================

MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_MAC, default 8: number of MAC units, each with one A-row FIFO.
REQ-002 SHALL have parameter DEPTH, default 8: words per FIFO, which is also the vector length.
REQ-003 SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begin a load-and-compute job; sampled only in IDLE.
REQ-007 SHALL have ports ld_valid (input, 1), ld_ready (output, 1) and ld_data (input, DATA_WIDTH): the load stream.
REQ-008 SHALL have port fifo_wdata, output, DATA_WIDTH: shared write data to all NUM_MAC+1 FIFOs.
REQ-009 SHALL have ports wren and rden, outputs, NUM_MAC+1 bits each: per-FIFO write and read enables; index NUM_MAC is the B-vector FIFO.
REQ-010 SHALL have ports full and empty, inputs, NUM_MAC+1 bits each: per-FIFO status.
REQ-011 SHALL have ports mac_en and mac_clr, outputs, NUM_MAC bits each: accumulate enable and accumulator clear.
REQ-012 SHALL have ports busy and done, outputs, 1 bit each: job active, and a one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, FILL, COMPUTE, FLUSH and DONE.
REQ-014 IDLE: on start=1, go to CLEAR; otherwise remain in IDLE.
REQ-015 CLEAR: assert mac_clr all-ones for exactly one cycle, then go to FILL with fifo_idx=0 and word_cnt=0.
REQ-016 FILL: ld_ready = !full[fifo_idx]; fifo_wdata = ld_data, combinational passthrough.
REQ-017 FILL: wren[fifo_idx] = ld_valid & ld_ready (combinational); all other wren bits are 0.
REQ-018 FILL: each accepted word increments word_cnt; on word DEPTH-1, clear word_cnt and increment fifo_idx.
REQ-019 FILL: on acceptance of word DEPTH-1 of FIFO NUM_MAC, go to COMPUTE; the total accepted is (NUM_MAC+1)*DEPTH words.
REQ-020 Outside FILL, ld_ready and all wren bits SHALL be 0.
REQ-021 COMPUTE: when no empty bit is set, drive all NUM_MAC+1 rden bits to 1 and increment rd_cnt.
REQ-022 COMPUTE: when any empty bit is set, drive all rden bits to 0 (stall) and hold rd_cnt.
REQ-023 COMPUTE: after the read with rd_cnt = DEPTH-1, go to FLUSH; there are exactly DEPTH read cycles.
REQ-024 mac_en SHALL equal the registered rden[0] replicated NUM_MAC times, i.e. 1-cycle FIFO read latency.
REQ-025 FLUSH: lasts one cycle so the last read is accumulated; rden=0; then go to DONE.
REQ-026 DONE: done=1 for one cycle, then go to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start asserted while busy SHALL be ignored and not queued.
REQ-029 Counters: word_cnt and rd_cnt are $clog2(DEPTH) bits wide, fifo_idx is $clog2(NUM_MAC+1) bits; none wrap past their terminal value.
REQ-030 A job SHALL produce exactly DEPTH mac_en pulses and exactly one mac_clr pulse.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE and clear all counters and the mac_en register.
REQ-032 During reset, every output SHALL be 0: wren, rden, mac_en, mac_clr, ld_ready, busy, done and fifo_wdata.
REQ-033 Reset asserted mid-FILL or mid-COMPUTE SHALL abort the job with no done pulse; the FIFOs are reset by the same rst_n.

Verification
REQ-034 Nominal: start, then 72 words with ld_valid held 1 -> COMPUTE entered after word 72, 8 rden cycles, 8 mac_en cycles delayed 1, done pulse; start to done = 1+72+8+1+1 cycles.
REQ-035 Load backpressure: ld_valid toggling 1/0 -> only handshaked words are written; the wren count per FIFO is exactly 8.
REQ-036 Full stall: force full[3]=1 while fifo_idx=3 -> ld_ready=0 and wren=0 until release, then resume with no word lost.
REQ-037 Empty stall: force empty[8]=1 for 3 cycles mid-COMPUTE -> rden=0 for those 3 cycles, rd_cnt held, total rden cycles still 8.
REQ-038 Reset mid-COMPUTE at rd_cnt=4 -> all outputs 0 immediately, state IDLE, no done; a new start runs a full job.
REQ-039 start pulsed during FILL -> no effect; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// Sequencer for a NUM_MAC-wide MAC array: loads the A-row FIFOs and the B-vector
// FIFO from one stream, then streams DEPTH lock-step reads into the accumulators.
module mac_array_ctrl #(
  parameter int NUM_MAC    = 8,
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  // Load stream: a word transfers on a rising edge where ld_valid && ld_ready.
  // ld_ready never depends on ld_valid; ld_data must hold while ld_valid && !ld_ready.
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [NUM_MAC:0]      wren,
  output logic [NUM_MAC:0]      rden,
  input  logic [NUM_MAC:0]      full,
  input  logic [NUM_MAC:0]      empty,
  output logic [NUM_MAC-1:0]    mac_en,
  output logic [NUM_MAC-1:0]    mac_clr,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            o_dbg_state
);

  localparam int WC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FI_W = $clog2(NUM_MAC + 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(DEPTH - 1);
  localparam logic [FI_W-1:0] LAST_FIFO = FI_W'(NUM_MAC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_FILL    = 3'd2,
    S_COMPUTE = 3'd3,
    S_FLUSH   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [FI_W-1:0]   r_fifo_idx;
  logic [WC_W-1:0]   r_word_cnt;
  logic [WC_W-1:0]   r_rd_cnt;
  logic              r_mac_en;

  logic              w_sel_full;
  logic [NUM_MAC:0]  w_sel_onehot;
  logic              w_fill_ready;
  logic              w_accept;
  logic              w_last_word;
  logic              w_last_fifo;
  logic              w_can_read;
  logic              w_last_read;

  // Decode the FIFO currently being filled without a variable part-select.
  always_comb begin
    w_sel_full   = 1'b0;
    w_sel_onehot = '0;
    for (int k = 0; k <= NUM_MAC; k++) begin
      if (r_fifo_idx == FI_W'(k)) begin
        w_sel_full      = full[k];
        w_sel_onehot[k] = 1'b1;
      end
    end
  end

  assign w_fill_ready = (r_state == S_FILL) && !w_sel_full;
  assign w_accept     = w_fill_ready && ld_valid;
  assign w_last_word  = (r_word_cnt == LAST_WORD);
  assign w_last_fifo  = (r_fifo_idx == LAST_FIFO);
  // All FIFOs advance together, so a single empty one stalls the whole array.
  assign w_can_read   = (r_state == S_COMPUTE) && !(|empty);
  assign w_last_read  = (r_rd_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_FILL;
      S_FILL:    if (w_accept && w_last_word && w_last_fifo) w_next = S_COMPUTE;
      S_COMPUTE: if (w_can_read && w_last_read) w_next = S_FLUSH;
      S_FLUSH:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ld_ready   = 1'b0;
    fifo_wdata = '0;
    wren       = '0;
    rden       = '0;
    mac_clr    = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE:    busy = 1'b0;
      S_CLEAR:   mac_clr = '1;
      S_FILL: begin
        ld_ready   = w_fill_ready;
        fifo_wdata = ld_data;
        wren       = w_accept ? w_sel_onehot : '0;
      end
      S_COMPUTE: rden = {(NUM_MAC + 1){w_can_read}};
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_idx <= '0;
      r_word_cnt <= '0;
      r_rd_cnt   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_fifo_idx <= '0;
          r_word_cnt <= '0;
          r_rd_cnt   <= '0;
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              r_fifo_idx <= w_last_fifo ? '0 : r_fifo_idx + FI_W'(1);
            end else begin
              r_word_cnt <= r_word_cnt + WC_W'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (w_can_read) begin
            r_rd_cnt <= w_last_read ? '0 : r_rd_cnt + WC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO read data appears one cycle after rden, so the accumulate enable lags by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mac_en <= 1'b0;
    end else begin
      r_mac_en <= rden[0];
    end
  end

  assign mac_en      = {NUM_MAC{r_mac_en}};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: nominal job, load backpressure, full and
// empty stalls, reset mid-compute and start pulsed while busy.
module tb_mac_array_ctrl;

  localparam int NM    = 8;
  localparam int DP    = 8;
  localparam int DW    = 8;
  localparam int TOTAL = (NM + 1) * DP;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] fifo_wdata;
  logic [NM:0]   wren;
  logic [NM:0]   rden;
  logic [NM:0]   full;
  logic [NM:0]   empty;
  logic [NM-1:0] mac_en;
  logic [NM-1:0] mac_clr;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  int n_pass;
  int n_fail;
  int n_total;

  logic [DW-1:0] exp_q[$];

  int        wr_cnt[NM+1];
  int        wr_total;
  int        rd_cycles;
  int        en_cycles;
  int        clr_pulses;
  int        done_pulses;
  int        busy_cycles;
  int        lat_err;
  int        data_err;
  int        onehot_err;
  int        rden_err;
  int        last_wr_cyc;
  int        first_rd_cyc;
  logic [NM-1:0] clr_val;
  bit        prev_rden0;
  bit        job_ended;

  mac_array_ctrl #(
    .NUM_MAC    (NM),
    .DEPTH      (DP),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .fifo_wdata  (fifo_wdata),
    .wren        (wren),
    .rden        (rden),
    .full        (full),
    .empty       (empty),
    .mac_en      (mac_en),
    .mac_clr     (mac_clr),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] word_of(input int n);
    return DW'(n * 7 + 3);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_wren"}, wren, 0);
    chk({tag, "_rden"}, rden, 0);
    chk({tag, "_mac_en"}, mac_en, 0);
    chk({tag, "_mac_clr"}, mac_clr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wdata"}, fifo_wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  // Driver + monitor for one job. abort_rd > 0 asserts reset once that many reads were seen.
  task automatic run_job(input bit tog_valid, input bit stall_full, input bit stall_empty,
                         input bit start_in_fill, input int abort_rd);
    int n;
    int cyc;
    int full_left;
    int empty_left;
    logic [NM:0] exp_w;
    n = 0; cyc = 0; full_left = 4; empty_left = 3; job_ended = 0;
    foreach (wr_cnt[k]) wr_cnt[k] = 0;
    wr_total = 0; rd_cycles = 0; en_cycles = 0; clr_pulses = 0; done_pulses = 0;
    busy_cycles = 0; lat_err = 0; data_err = 0; onehot_err = 0; rden_err = 0;
    last_wr_cyc = -1; first_rd_cyc = -1; clr_val = '0; prev_rden0 = 1'b0;
    exp_q.delete();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(word_of(i));
    start = 1'b1;
    step();
    start = 1'b0;
    while (!job_ended && cyc < 400) begin
      ld_valid = (n < TOTAL) && (!tog_valid || (cyc % 2 == 0));
      ld_data  = word_of(n);
      full     = '0;
      empty    = '0;
      start    = start_in_fill && (cyc == 20);
      if (stall_full && n == 27 && full_left > 0) begin
        full[3] = 1'b1;
        full_left--;
      end
      if (stall_empty && rd_cycles == 3 && empty_left > 0) begin
        empty[NM] = 1'b1;
        empty_left--;
      end
      @(negedge clk);
      if (full[3]) begin
        chk("full_stall_ready", ld_ready, 0);
        chk("full_stall_wren", wren, 0);
      end
      if (empty[NM]) chk("empty_stall_rden", rden, 0);
      if (busy) busy_cycles++;
      if (mac_en !== {NM{prev_rden0}}) lat_err++;
      prev_rden0 = rden[0];
      if (wren != 0) begin
        exp_w = 1;
        exp_w = exp_w << (wr_total / DP);
        if (wren !== exp_w) onehot_err++;
        for (int k = 0; k <= NM; k++) if (wren[k]) wr_cnt[k]++;
        if (exp_q.size() == 0) data_err++;
        else if (fifo_wdata !== exp_q.pop_front()) data_err++;
        wr_total++;
        last_wr_cyc = cyc;
      end
      if (rden != 0) begin
        if (rden !== '1) rden_err++;
        if (rd_cycles == 0) first_rd_cyc = cyc;
        rd_cycles++;
      end
      if (mac_en != 0) en_cycles++;
      if (mac_clr != 0) begin
        clr_pulses++;
        clr_val = mac_clr;
      end
      if (done) begin
        done_pulses++;
        job_ended = 1;
      end
      if (ld_valid && ld_ready) n++;
      step();
      cyc++;
      if (abort_rd > 0 && rd_cycles == abort_rd && !job_ended) begin
        chk("abort_in_compute", dbg_state, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        job_ended = 1;
      end
    end
    chk("job_timeout", job_ended, 1);
    ld_valid = 1'b0;
    start    = 1'b0;
    full     = '0;
    empty    = '0;
  endtask

  task automatic check_full_job(input string tag, input int exp_busy);
    chk({tag, "_busy_cycles"}, busy_cycles, exp_busy);
    chk({tag, "_wr_total"}, wr_total, TOTAL);
    for (int k = 0; k <= NM; k++) chk({tag, "_wr_cnt"}, wr_cnt[k], DP);
    chk({tag, "_data_err"}, data_err, 0);
    chk({tag, "_onehot_err"}, onehot_err, 0);
    chk({tag, "_exp_q_left"}, exp_q.size(), 0);
    chk({tag, "_rd_cycles"}, rd_cycles, DP);
    chk({tag, "_rden_err"}, rden_err, 0);
    chk({tag, "_en_cycles"}, en_cycles, DP);
    chk({tag, "_lat_err"}, lat_err, 0);
    chk({tag, "_clr_pulses"}, clr_pulses, 1);
    chk({tag, "_clr_val"}, clr_val, {NM{1'b1}});
    chk({tag, "_done_pulses"}, done_pulses, 1);
    chk({tag, "_idle_state"}, dbg_state, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b1; ld_valid = 1'b1; ld_data = 8'hA5;
    full = '0; empty = '1;
    #12;
    check_all_zero("reset");
    start = 1'b0; ld_valid = 1'b0; empty = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // Nominal: 72 words back to back, compute starts the cycle after the last word
    run_job(0, 0, 0, 0, 0);
    check_full_job("nominal", 83);
    chk("nominal_compute_after_fill", first_rd_cyc, last_wr_cyc + 1);

    // Load backpressure: ld_valid high every other cycle
    step();
    run_job(1, 0, 0, 0, 0);
    check_full_job("toggle_valid", 155);

    // full[3] forced for 4 cycles while filling FIFO 3
    step();
    run_job(0, 1, 0, 0, 0);
    check_full_job("full_stall", 87);

    // empty[8] forced for 3 cycles after the third read
    step();
    run_job(0, 0, 1, 0, 0);
    check_full_job("empty_stall", 86);

    // start pulsed mid-FILL must not queue a second job
    step();
    run_job(0, 0, 0, 1, 0);
    check_full_job("start_in_fill", 83);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_queued_start_busy", busy, 0);
    end

    // Reset at rd_cnt=4 aborts the job without a done pulse
    step();
    run_job(0, 0, 0, 0, 4);
    chk("abort_done_pulses", done_pulses, 0);
    chk("abort_rd_cycles", rd_cycles, 4);
    step();
    check_all_zero("abort_held");
    rst_n = 1'b1;
    step();
    run_job(0, 0, 0, 0, 0);
    check_full_job("after_abort", 83);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
